// File: rtl/call_frame_stack.sv
// Call-frame stack: the top frame is held in registers, lower frames sit in a synchronous-read RAM.
// Optional high-water mark on max_depth is enabled by defining CALL_FRAME_STACK_WATERMARK_EN.
module call_frame_stack #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_ret_addr,
  input  logic [ADDR_WIDTH-1:0] push_tos,
  input  logic [ADDR_WIDTH-1:0] push_base,
  input  logic                  err_clr,
  output logic                  ready,
  output logic                  top_valid,
  output logic [ADDR_WIDTH-1:0] top_ret_addr,
  output logic [ADDR_WIDTH-1:0] top_tos,
  output logic [ADDR_WIDTH-1:0] top_base,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DEPTH_LOG2:0]   max_depth
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int FW    = 3 * ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_next;

  logic [FW-1:0]         mem [DEPTH];
  logic [FW-1:0]         rd_data;
  logic [CW-1:0]         count_q, count_next;
  logic [ADDR_WIDTH-1:0] ret_q, tos_q, base_q;
  logic                  ovf_q, unf_q;
  logic                  is_idle, is_full, is_empty;
  logic                  do_push, do_pop, do_tail, push_rej, pop_rej;
  logic                  spill, refill_start;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;

  assign is_idle  = (state == IDLE);
  assign is_full  = (count_q == DEPTH_CNT);
  assign is_empty = (count_q == '0);

  assign do_push  = is_idle & push & ~pop & ~is_full;
  assign push_rej = is_idle & push & ~pop & is_full;
  assign do_pop   = is_idle & pop & ~push & ~is_empty;
  assign pop_rej  = is_idle & pop & ~push & is_empty;
  assign do_tail  = is_idle & push & pop;

  assign spill        = do_push & ~is_empty;
  assign refill_start = do_pop & (count_q > CNT_ONE);

  assign wr_idx = DEPTH_LOG2'(count_q - CNT_ONE);
  assign rd_idx = DEPTH_LOG2'(count_q - CW'(2));

  always_comb begin
    count_next = count_q;
    if (do_push || (do_tail && is_empty))
      count_next = count_q + CNT_ONE;
    else if (do_pop)
      count_next = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (refill_start) state_next = REFILL;
      REFILL:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  // RAM has no reset; the write is gated so a reset cycle cannot spill a frame.
  always_ff @(posedge clk) begin
    if (!reset && spill)
      mem[wr_idx] <= {ret_q, tos_q, base_q};
    if (refill_start)
      rd_data <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ret_q   <= '0;
      tos_q   <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_next;
      if (do_push || do_tail) begin
        ret_q  <= push_ret_addr;
        tos_q  <= push_tos;
        base_q <= push_base;
      end else if (state == REFILL) begin
        {ret_q, tos_q, base_q} <= rd_data;
      end
      // A new error event takes priority over a simultaneous clear.
      if (push_rej)     ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (pop_rej)      unf_q <= 1'b1;
      else if (err_clr) unf_q <= 1'b0;
    end
  end

`ifdef CALL_FRAME_STACK_WATERMARK_EN
  logic [CW-1:0] max_q;

  always_ff @(posedge clk) begin
    if (reset)                  max_q <= '0;
    else if (count_next > max_q) max_q <= count_next;
  end

  assign max_depth = max_q;
`else
  assign max_depth = '0;
`endif

  assign top_valid    = ~is_empty;
  assign top_ret_addr = ret_q;
  assign top_tos      = tos_q;
  assign top_base     = base_q;
  assign count        = count_q;
  assign full         = is_full;
  assign empty        = is_empty;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_call_frame_stack.sv
// Directed self-checking bench for call_frame_stack, built with a 4-frame stack.
// Watermark expectations follow CALL_FRAME_STACK_WATERMARK_EN.
module tb_call_frame_stack;

  localparam int AW = 12;
  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          reset, push, pop, err_clr;
  logic [AW-1:0] push_ret_addr, push_tos, push_base;
  logic          ready, top_valid, full, empty, overflow, underflow;
  logic [AW-1:0] top_ret_addr, top_tos, top_base;
  logic [DL:0]   count, max_depth;

  int checkCount = 0;
  int failCount  = 0;

  call_frame_stack #(.ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .push_ret_addr(push_ret_addr), .push_tos(push_tos), .push_base(push_base),
    .err_clr(err_clr), .ready(ready), .top_valid(top_valid),
    .top_ret_addr(top_ret_addr), .top_tos(top_tos), .top_base(top_base),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .underflow(underflow), .max_depth(max_depth)
  );

  always #5 clk = ~clk;

  // Compares an observed output against its hand-computed value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic p, input logic q, input logic [AW-1:0] ret,
                               input logic [AW-1:0] tos, input logic [AW-1:0] base,
                               input logic clr);
    push = p; pop = q; push_ret_addr = ret; push_tos = tos; push_base = base;
    err_clr = clr;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [DL:0] wmExpect;

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    push_ret_addr = '0; push_tos = '0; push_base = '0;
    resetDut();
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_top_valid", top_valid, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_unf", underflow, 0);
    checkOutput("rst_max", max_depth, 0);
    checkOutput("rst_top_ret", top_ret_addr, 0);

    // Three calls
    applyStimulus(1, 0, 12'h010, 12'h101, 12'h201, 0);
    checkOutput("p1_ready", ready, 1);
    checkOutput("p1_count", count, 1);
    checkOutput("p1_valid", top_valid, 1);
    applyStimulus(1, 0, 12'h020, 12'h102, 12'h202, 0);
    checkOutput("p2_ready", ready, 1);
    applyStimulus(1, 0, 12'h030, 12'h103, 12'h203, 0);
    checkOutput("p3_ready", ready, 1);
    checkOutput("p3_count", count, 3);
    checkOutput("p3_ret", top_ret_addr, 12'h030);
    checkOutput("p3_tos", top_tos, 12'h103);
    checkOutput("p3_base", top_base, 12'h203);

    // Return with refill
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("pop_refill_ready", ready, 0);
    checkOutput("pop_refill_count", count, 2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("pop_done_ready", ready, 1);
    checkOutput("pop_done_ret", top_ret_addr, 12'h020);
    checkOutput("pop_done_tos", top_tos, 12'h102);
    checkOutput("pop_done_base", top_base, 12'h202);

    // Tail call replaces the top frame in place
    applyStimulus(1, 1, 12'h0AA, 12'h1AA, 12'h2AA, 0);
    checkOutput("tail_count", count, 2);
    checkOutput("tail_ret", top_ret_addr, 12'h0AA);
    checkOutput("tail_tos", top_tos, 12'h1AA);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("tail_pop_count", count, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("tail_pop_ret", top_ret_addr, 12'h010);
    checkOutput("tail_pop_tos", top_tos, 12'h101);

    // Fill to capacity, then overflow
    applyStimulus(1, 0, 12'h040, 12'h104, 12'h204, 0);
    applyStimulus(1, 0, 12'h050, 12'h105, 12'h205, 0);
    applyStimulus(1, 0, 12'h060, 12'h106, 12'h206, 0);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_count", count, 4);
    checkOutput("fill_ovf", overflow, 0);
    applyStimulus(1, 0, 12'h070, 12'h107, 12'h207, 0);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_count", count, 4);
    checkOutput("ovf_top_ret", top_ret_addr, 12'h060);
    checkOutput("ovf_top_tos", top_tos, 12'h106);
    wmExpect = 3'd0;
`ifdef CALL_FRAME_STACK_WATERMARK_EN
    wmExpect = 3'd4;
`endif
    checkOutput("wm_full", max_depth, wmExpect);

    // Drain; a push during REFILL must be ignored
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("drain1_count", count, 3);
    applyStimulus(1, 0, 12'h0EE, 12'h1EE, 12'h2EE, 0);
    checkOutput("refill_ignore_count", count, 3);
    checkOutput("refill_ignore_ret", top_ret_addr, 12'h050);
    checkOutput("refill_ignore_ready", ready, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drain2_ret", top_ret_addr, 12'h040);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drain3_ret", top_ret_addr, 12'h010);
    checkOutput("drain3_count", count, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("drain4_ready", ready, 1);
    checkOutput("drain4_empty", empty, 1);
    checkOutput("drain4_valid", top_valid, 0);
    checkOutput("drain4_ret_kept", top_ret_addr, 12'h010);
    checkOutput("drain4_unf", underflow, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("unf_flag", underflow, 1);
    checkOutput("unf_count", count, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("clr_ovf", overflow, 0);
    checkOutput("clr_unf", underflow, 0);
    // Error event coincident with clear keeps the flag set
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("clr_vs_err_unf", underflow, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("clr2_unf", underflow, 0);
    // Tail call on empty stack acts as a push
    applyStimulus(1, 1, 12'h0BB, 12'h1BB, 12'h2BB, 0);
    checkOutput("tail_empty_count", count, 1);
    checkOutput("tail_empty_ret", top_ret_addr, 12'h0BB);
    checkOutput("tail_empty_unf", underflow, 0);

    // Reset during REFILL
    resetDut();
    applyStimulus(1, 0, 12'h011, 12'h111, 12'h211, 0);
    applyStimulus(1, 0, 12'h022, 12'h122, 12'h222, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("rr_in_refill", ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rr_count", count, 0);
    checkOutput("rr_empty", empty, 1);
    checkOutput("rr_ready", ready, 1);
    applyStimulus(1, 0, 12'h033, 12'h133, 12'h233, 0);
    checkOutput("rr_push_count", count, 1);
    checkOutput("rr_push_ret", top_ret_addr, 12'h033);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("rr_pop_count", count, 0);
    checkOutput("rr_pop_ready", ready, 1);

    // Watermark: push 3, pop 2, push 1
    resetDut();
    applyStimulus(1, 0, 12'h001, 12'h101, 12'h201, 0);
    applyStimulus(1, 0, 12'h002, 12'h102, 12'h202, 0);
    applyStimulus(1, 0, 12'h003, 12'h103, 12'h203, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 12'h004, 12'h104, 12'h204, 0);
    checkOutput("wm_count", count, 2);
    checkOutput("wm_ret", top_ret_addr, 12'h004);
    wmExpect = 3'd0;
`ifdef CALL_FRAME_STACK_WATERMARK_EN
    wmExpect = 3'd3;
`endif
    checkOutput("wm_max", max_depth, wmExpect);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("wm_after_clr", max_depth, wmExpect);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/call_frame_stack.md
Name: call_frame_stack

Overview:
Hardware call-frame stack for the bytecode core. It saves the caller's return address, operand-stack TOS and locals base on CALL and restores them on RETURN. The top frame is held in registers so it is always visible to the control unit; lower frames live in a synchronous-read stack RAM. This block replaces the separate fixed-depth function and TOS stacks with a single parametrised unit that adds full/empty, overflow/underflow and tail-call support.

Parameters:
ADDR_WIDTH, 12, width of each saved field (return PC, TOS, locals base)
DEPTH_LOG2, 4, log2 of the maximum frame count; DEPTH = 2**DEPTH_LOG2 frames (1 in the top register, DEPTH-1 in RAM)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
push  in  1  save frame (CALL); accepted only when ready=1
pop  in  1  discard top frame (RETURN); accepted only when ready=1
push_ret_addr  in  ADDR_WIDTH  return PC to save
push_tos  in  ADDR_WIDTH  operand-stack TOS to save
push_base  in  ADDR_WIDTH  locals base to save
err_clr  in  1  clears the overflow and underflow sticky flags
ready  out  1  1 in IDLE; 0 during REFILL
top_valid  out  1  count != 0
top_ret_addr  out  ADDR_WIDTH  top frame return PC (registered)
top_tos  out  ADDR_WIDTH  top frame TOS (registered)
top_base  out  ADDR_WIDTH  top frame locals base (registered)
count  out  DEPTH_LOG2+1  number of frames held
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: a push was rejected because the stack was full
underflow  out  1  sticky: a pop was rejected because the stack was empty
max_depth  out  DEPTH_LOG2+1  high-water mark of count (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, count=0, top_* =0, overflow=0, underflow=0, max_depth=0. Outputs: ready=1, top_valid=0, empty=1, full=0.
- Reset wins over every other input. Reset during REFILL abandons the refill; the next cycle is IDLE with an empty stack.
- RAM: DEPTH entries, synchronous write, registered read with 1-cycle latency. Only indices 0..DEPTH-2 are used. Entry i holds the frame at stack position i, where 0 is the bottom frame.
- State machine: two states, IDLE and REFILL.
- IDLE, push only, count<DEPTH:
  - If count>0, write the top register to RAM[count-1].
  - Load top_* from the push_* inputs.
  - count+1. Stay in IDLE. Latency is 1 cycle.
- IDLE, push only, full: push is ignored and overflow<=1.
- IDLE, pop only, count==1: count<=0; top_* keep their old values. Stay in IDLE.
- IDLE, pop only, count>=2:
  - Issue a RAM read at count-2 and set count-1 immediately.
  - Go to REFILL; ready=0 for one cycle.
  - REFILL: load top_* from RAM read data, return to IDLE.
  - The restored frame is therefore visible 2 cycles after the pop cycle.
- IDLE, pop only, empty: pop is ignored and underflow<=1.
- IDLE, push and pop together (tail call):
  - If count>0: load top_* from push_*, count unchanged, no RAM access.
  - If empty: treat as a plain push, count<=1; underflow is not set.
- REFILL: push and pop are ignored, with no side effects and no error flags.
- Callers must sample top_* before, or in the same cycle as, the pop.
- err_clr clears both sticky flags. If err_clr coincides with a new error event, the error event wins (flag=1).
- count never wraps; the full/empty guards make wrap impossible.

Optional Feature:
- Macro: CALL_FRAME_STACK_WATERMARK_EN.
- Defined: max_depth register updates to count_next whenever count_next > max_depth. It is cleared only by reset; err_clr does not clear it.
- Undefined: max_depth is tied to 0 and no register is inferred.

Test Plan:
1. Reset, then 3 pushes (ret 0x010/0x020/0x030, tos 0x101/0x102/0x103, base 0x201/0x202/0x203) -> count=3; top_ret_addr=0x030, top_tos=0x103, top_base=0x203; ready stays 1 throughout.
2. From case 1, pop -> ready=0 for one cycle; count=2 in that cycle; next cycle top_ret_addr=0x020, top_tos=0x102; ready=1.
3. With DEPTH_LOG2=2, 4 pushes then a 5th push -> full=1, count=4, overflow=1, top unchanged. Pop until empty; a further pop -> underflow=1. err_clr -> both flags 0.
4. count=2 (top ret 0x020), push and pop together with ret 0x0AA -> count=2, top_ret_addr=0x0AA. A following pop restores ret 0x010.
5. Assert reset during REFILL -> next cycle count=0, empty=1, ready=1. A push then gives count=1 with no stale frame.
6. With CALL_FRAME_STACK_WATERMARK_EN defined: push 3, pop 2, push 1 -> max_depth=3, count=2. Without the macro -> max_depth=0.
